// File: rtl/bpu_update_queue_if.sv
// Commit-side and predictor-update-side handshake bundle for the branch update queue.
// The queue attaches through 'slave'; the commit stage / predictor side uses 'master'.
interface bpu_update_queue_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PLEN         = 32
);
  logic [COMMIT_WIDTH-1:0]           commit_valid_i;
  logic [COMMIT_WIDTH-1:0][PLEN-1:0] commit_pc_i;
  logic [COMMIT_WIDTH-1:0]           commit_is_cond_i;
  logic [COMMIT_WIDTH-1:0]           commit_taken_i;
  logic [COMMIT_WIDTH-1:0][PLEN-1:0] commit_target_i;
  logic                              commit_ready_o;

  logic                              update_valid_o;
  logic                              update_ready_i;
  logic [PLEN-1:0]                   update_pc_o;
  logic                              update_is_cond_o;
  logic                              update_taken_o;
  logic [PLEN-1:0]                   update_target_o;

  modport master (
    output commit_valid_i, commit_pc_i, commit_is_cond_i, commit_taken_i, commit_target_i,
    input  commit_ready_o,
    input  update_valid_o, update_pc_o, update_is_cond_o, update_taken_o, update_target_o,
    output update_ready_i
  );

  modport slave (
    input  commit_valid_i, commit_pc_i, commit_is_cond_i, commit_taken_i, commit_target_i,
    output commit_ready_o,
    output update_valid_o, update_pc_o, update_is_cond_o, update_taken_o, update_target_o,
    input  update_ready_i
  );
endinterface

// File: rtl/bpu_update_queue.sv
// In-order queue of resolved branch records: accepts up to COMMIT_WIDTH compacted
// records per cycle from commit and drains one per cycle into the predictor update port.
module bpu_update_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PLEN         = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  bpu_update_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PLEN-1:0] pc_mem     [DEPTH];
  logic [PLEN-1:0] target_mem [DEPTH];
  logic            cond_mem   [DEPTH];
  logic            taken_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] push_cnt;
  logic [PTR_W-1:0] slot_addr [COMMIT_WIDTH];
  logic             push_en;
  logic             pop_en;

  // Each valid slot lands at wr_ptr plus the number of valid slots below it,
  // which squeezes out holes in sparse masks while keeping slot order.
  always_comb begin
    push_cnt = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      slot_addr[s] = wr_ptr_reg + push_cnt[PTR_W-1:0];
      push_cnt     = push_cnt + CNT_W'(bus.commit_valid_i[s]);
    end
  end

  // Ready only looks at registered occupancy, so a same-cycle pop never grants credit.
  assign free_slots         = CNT_W'(DEPTH) - count_reg;
  assign bus.commit_ready_o = free_slots >= CNT_W'(COMMIT_WIDTH);
  assign push_en            = bus.commit_ready_o;
  assign pop_en             = (count_reg != '0) && bus.update_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]     <= '0;
        target_mem[i] <= '0;
        cond_mem[i]   <= 1'b0;
        taken_mem[i]  <= 1'b0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
          if (bus.commit_valid_i[s]) begin
            pc_mem[slot_addr[s]]     <= bus.commit_pc_i[s];
            target_mem[slot_addr[s]] <= bus.commit_target_i[s];
            cond_mem[slot_addr[s]]   <= bus.commit_is_cond_i[s];
            taken_mem[slot_addr[s]]  <= bus.commit_taken_i[s];
          end
        end
        wr_ptr_reg <= wr_ptr_reg + push_cnt[PTR_W-1:0];
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + (push_en ? push_cnt : '0) - CNT_W'(pop_en);
    end
  end

  // Fields are stale whenever the queue is empty; consumers qualify with update_valid_o.
  assign bus.update_valid_o   = (count_reg != '0);
  assign bus.update_pc_o      = pc_mem[rd_ptr_reg];
  assign bus.update_target_o  = target_mem[rd_ptr_reg];
  assign bus.update_is_cond_o = cond_mem[rd_ptr_reg];
  assign bus.update_taken_o   = taken_mem[rd_ptr_reg];
  assign count_o              = count_reg;

  assert property (@(posedge clk_i) disable iff (rst_i) count_reg <= CNT_W'(DEPTH));
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !bus.commit_ready_o |=> $stable(wr_ptr_reg));
endmodule

// File: tb/tb_bpu_update_queue.sv
// Randomised and directed bench for bpu_update_queue against a queue-of-records model.
module tb_bpu_update_queue;
  localparam int CW    = 2;
  localparam int DEPTH = 8;
  localparam int PLEN  = 32;

  typedef struct packed {
    logic [PLEN-1:0] pc;
    logic            cond;
    logic            taken;
    logic [PLEN-1:0] tgt;
  } rec_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] count_o;

  bpu_update_queue_if #(.COMMIT_WIDTH(CW), .PLEN(PLEN)) bus ();

  bpu_update_queue #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .PLEN(PLEN)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  int   vectors     = 0;
  int   miscompares = 0;
  rec_t model_q[$];
  int   delivered   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc    = $urandom;
    r.cond  = 1'($urandom_range(0, 1));
    r.taken = 1'($urandom_range(0, 1));
    r.tgt   = $urandom;
    return r;
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic c, input logic t,
                                  input logic [31:0] tgt);
    rec_t r;
    r.pc = pc; r.cond = c; r.taken = t; r.tgt = tgt;
    return r;
  endfunction

  // Compare DUT outputs with the model's view of the queue.
  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check_value("count", 64'(count_o), 64'(sz));
    check_value("commit_ready", 64'(bus.commit_ready_o), 64'((DEPTH - sz) >= CW));
    check_value("update_valid", 64'(bus.update_valid_o), 64'(sz != 0));
    if (sz != 0) begin
      check_value("head_pc", 64'(bus.update_pc_o), 64'(model_q[0].pc));
      check_value("head_cond", 64'(bus.update_is_cond_o), 64'(model_q[0].cond));
      check_value("head_taken", 64'(bus.update_taken_o), 64'(model_q[0].taken));
      check_value("head_target", 64'(bus.update_target_o), 64'(model_q[0].tgt));
    end
  endtask

  // One clock: apply inputs, check current outputs, advance the model, cross the edge.
  task automatic run_cycle(input logic [1:0] mask, input rec_t r0, input rec_t r1,
                           input logic upd_rdy);
    bit   accept;
    rec_t head;
    bus.commit_valid_i      = mask;
    bus.commit_pc_i[0]      = r0.pc;
    bus.commit_is_cond_i[0] = r0.cond;
    bus.commit_taken_i[0]   = r0.taken;
    bus.commit_target_i[0]  = r0.tgt;
    bus.commit_pc_i[1]      = r1.pc;
    bus.commit_is_cond_i[1] = r1.cond;
    bus.commit_taken_i[1]   = r1.taken;
    bus.commit_target_i[1]  = r1.tgt;
    bus.update_ready_i      = upd_rdy;
    #1;
    check_outputs();
    accept = (DEPTH - model_q.size()) >= CW;
    if (model_q.size() != 0 && upd_rdy) begin
      head = model_q.pop_front();
      delivered++;
      $display("update #%0d pc=%08h cond=%0b taken=%0b target=%08h",
               delivered, head.pc, head.cond, head.taken, head.tgt);
    end
    if (accept) begin
      if (mask[0]) model_q.push_back(r0);
      if (mask[1]) model_q.push_back(r1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check_cleared(input string tag);
    check_value({tag, "_valid"}, 64'(bus.update_valid_o), 64'(0));
    check_value({tag, "_count"}, 64'(count_o), 64'(0));
    check_value({tag, "_ready"}, 64'(bus.commit_ready_o), 64'(1));
    check_value({tag, "_pc"}, 64'(bus.update_pc_o), 64'(0));
    check_value({tag, "_target"}, 64'(bus.update_target_o), 64'(0));
    check_value({tag, "_flags"}, 64'({bus.update_is_cond_o, bus.update_taken_o}), 64'(0));
  endtask

  initial begin
    rec_t z;
    int   k;
    z = '0;
    bus.commit_valid_i   = '0;
    bus.commit_pc_i      = '0;
    bus.commit_is_cond_i = '0;
    bus.commit_taken_i   = '0;
    bus.commit_target_i  = '0;
    bus.update_ready_i   = 1'b1;
    repeat (2) @(negedge clk_i);
    check_cleared("reset");
    rst_i = 1'b0;

    // Single push, presented one cycle later, then drained.
    run_cycle(2'b01, mk_rec(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0040), z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);

    // Dual push A then B.
    run_cycle(2'b11, mk_rec(32'h100, 1'b0, 1'b1, 32'h180), mk_rec(32'h104, 1'b1, 1'b0, 32'h108), 1'b1);
    run_cycle(2'b00, z, z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);

    // Sparse mask: slot 1 only.
    run_cycle(2'b10, rand_rec(), mk_rec(32'h200, 1'b1, 1'b0, 32'h240), 1'b0);
    run_cycle(2'b00, z, z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);

    // Fill with the predictor stalled; ready drops at 7, extra records are ignored.
    for (int i = 0; i < 3; i++) run_cycle(2'b11, rand_rec(), rand_rec(), 1'b0);
    run_cycle(2'b01, rand_rec(), rand_rec(), 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(2'b11, rand_rec(), rand_rec(), 1'b0);
    for (int i = 0; i < 9; i++) run_cycle(2'b00, z, z, 1'b1);

    // Wrap-around: 20 sequential records, 0/1/2 per cycle, commit holds when not ready.
    k = 0;
    while (k < 20) begin
      int   n;
      rec_t a, b;
      logic [1:0] m;
      n = $urandom_range(0, 2);
      if (k + n > 20) n = 20 - k;
      a = mk_rec(32'h1000 + 32'(4 * k), 1'b1, 1'(k), 32'h2000 + 32'(k));
      b = mk_rec(32'h1000 + 32'(4 * (k + 1)), 1'b0, 1'(k + 1), 32'h2000 + 32'(k + 1));
      if (n == 2) m = 2'b11;
      else if (n == 1) begin
        if ($urandom_range(0, 1) == 1) begin m = 2'b10; b = a; end
        else m = 2'b01;
      end else m = 2'b00;
      if ((DEPTH - model_q.size()) >= CW) k += n;
      run_cycle(m, a, b, 1'b1);
    end
    for (int i = 0; i < 10; i++) run_cycle(2'b00, z, z, 1'b1);

    // Random traffic with random predictor stalls.
    for (int i = 0; i < 300; i++) begin
      run_cycle(2'($urandom), rand_rec(), rand_rec(), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 10; i++) run_cycle(2'b00, z, z, 1'b1);

    // Asynchronous reset with five records pending.
    run_cycle(2'b11, rand_rec(), rand_rec(), 1'b0);
    run_cycle(2'b11, rand_rec(), rand_rec(), 1'b0);
    run_cycle(2'b01, rand_rec(), rand_rec(), 1'b0);
    check_value("pre_reset_count", 64'(count_o), 64'(5));
    #2 rst_i = 1'b1;
    #1 check_cleared("async_reset");
    model_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    run_cycle(2'b01, mk_rec(32'h3000, 1'b1, 1'b1, 32'h3100), z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);
    run_cycle(2'b00, z, z, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
